// File: rtl/alu_exec_unit.sv
// Handshaked ALU execution unit; shifts run serially one bit per cycle.
// Optional feature: define ALU_OVERFLOW_EN to add the signed-overflow output.
module alu_exec_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  alucontrol,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        illegal
`ifdef ALU_OVERFLOW_EN
    ,
    output logic        overflow
`endif
);

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 5;

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b1010;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_SLT = 4'b1011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [SW-1:0]   cnt_q;
    logic [SW-1:0]   cnt_d;
    logic            dir_q;
    logic            dir_d;
    logic [DW-1:0]   result_d;
    logic            zero_d;
    logic            illegal_d;
    logic            out_valid_d;
    logic            in_ready_d;
    logic            is_shift;
    logic [DW-1:0]   sum;
    logic [DW-1:0]   diff;
`ifdef ALU_OVERFLOW_EN
    logic            overflow_d;
`endif

    assign sum      = a + b;
    assign diff     = a - b;
    assign is_shift = (alucontrol == OP_SLL) || (alucontrol == OP_SRL);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. The acceptance edge already performs the first shift
    // bit, so a shift by k delivers k cycles after acceptance; SHIFT is only
    // needed while more than one bit remains.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = (is_shift && (shamt > SW'(1))) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (cnt_q == SW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and the shift working state
    always_comb begin
        result_d    = result;
        zero_d      = zero;
        illegal_d   = illegal;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
`ifdef ALU_OVERFLOW_EN
        overflow_d  = overflow;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    illegal_d = 1'b0;
                    cnt_d     = '0;
                    dir_d     = 1'b0;
`ifdef ALU_OVERFLOW_EN
                    overflow_d = 1'b0;
`endif
                    case (alucontrol)
                        OP_ADD: begin
                            result_d = sum;
`ifdef ALU_OVERFLOW_EN
                            overflow_d = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
`endif
                        end
                        OP_SUB: begin
                            result_d = diff;
`ifdef ALU_OVERFLOW_EN
                            overflow_d = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
`endif
                        end
                        OP_AND: result_d = a & b;
                        OP_OR:  result_d = a | b;
                        OP_SLT: result_d = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
                        OP_SLL: begin
                            if (shamt == '0) begin
                                result_d = b;
                            end else begin
                                result_d = {b[DW-2:0], 1'b0};
                                cnt_d    = SW'(shamt - SW'(1));
                            end
                        end
                        OP_SRL: begin
                            dir_d = 1'b1;
                            if (shamt == '0) begin
                                result_d = b;
                            end else begin
                                result_d = {1'b0, b[DW-1:1]};
                                cnt_d    = SW'(shamt - SW'(1));
                            end
                        end
                        default: begin
                            result_d  = '0;
                            illegal_d = 1'b1;
                        end
                    endcase
                    zero_d = (result_d == '0);
                end
            end
            SHIFT: begin
                result_d = dir_q ? {1'b0, result[DW-1:1]} : {result[DW-2:0], 1'b0};
                cnt_d    = SW'(cnt_q - SW'(1));
                zero_d   = (result_d == '0);
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef ALU_OVERFLOW_EN
            overflow  <= 1'b0;
`endif
        end else begin
            result    <= result_d;
            zero      <= zero_d;
            illegal   <= illegal_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            out_valid <= out_valid_d;
            in_ready  <= in_ready_d;
`ifdef ALU_OVERFLOW_EN
            overflow  <= overflow_d;
`endif
        end
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-002 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port in_valid, input, 1 bit: operation request valid.
REQ-004 The block SHALL have port in_ready, output, 1 bit: unit can accept an operation.
REQ-005 The block SHALL have port alucontrol, input, 4 bits: operation code from the ALU decoder.
REQ-006 The block SHALL have ports a and b, input, 32 bits each: operands.
REQ-007 The block SHALL have port shamt, input, 5 bits: shift amount.
REQ-008 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 The block SHALL have port result, output, 32 bits: operation result.
REQ-011 The block SHALL have port zero, output, 1 bit: result == 0.
REQ-012 The block SHALL have port illegal, output, 1 bit: held operation used an unsupported code.

Function
REQ-013 Opcodes SHALL be decoded as follows:
- 0010: a+b.
- 1010: a-b.
- 0000: a&b.
- 0001: a|b.
- 1011: signed a<b, giving 1 or 0.
- 0100: b<<shamt (SLL).
- 0101: b>>shamt (SRL, logical).
REQ-014 Any other code SHALL produce result=0 and illegal=1, completing in the same cycle as a non-shift op.
REQ-015 The unit SHALL be a 3-state FSM: IDLE, SHIFT, DONE.
REQ-016 Acceptance SHALL occur on a rising edge where in_valid and in_ready are both 1.
REQ-017 in_ready SHALL be 1 only in IDLE.
REQ-018 Non-shift operations SHALL follow IDLE->DONE on acceptance, with out_valid=1 in the next cycle (latency 1).
REQ-019 Shift operations with shamt=k>0 SHALL follow IDLE->SHIFT, shifting by exactly 1 bit per cycle for k cycles, then moving to DONE; out_valid SHALL be 1 exactly k cycles after acceptance.
REQ-020 Shift operations with shamt=0 SHALL go directly to DONE with result=b.
REQ-021 Operands and opcode SHALL be captured at acceptance; input changes after acceptance SHALL have no effect.
REQ-022 In DONE, result, zero and illegal SHALL be held stable while out_ready=0.
REQ-023 DONE->IDLE SHALL occur on an edge with out_ready=1; out_valid and in_ready SHALL NOT both be 1 in the same cycle.
REQ-024 Add and sub SHALL wrap modulo 2^32.
REQ-025 zero SHALL equal (result==0) and SHALL be valid only while out_valid=1.

Reset
REQ-026 reset_n=0 SHALL, asynchronously, force state=IDLE and out_valid=0, and clear result, zero, illegal and all captured operands to 0; in_ready SHALL then be 1.
REQ-027 Reset asserted mid-shift or in DONE SHALL abandon the operation with no result delivered.
REQ-028 Deassertion of reset_n SHALL be sampled on clk; the first acceptance SHALL be possible on the first edge after deassertion.

Configuration
REQ-029 With macro ALU_OVERFLOW_EN defined, the unit SHALL add output overflow (1 bit), set for signed overflow of add/sub, 0 for all other ops, cleared by reset, and held in DONE like result.
REQ-030 Without ALU_OVERFLOW_EN, the overflow port SHALL be absent and add/sub SHALL wrap silently.

Verification
REQ-031 Add test: a=5, b=7, code 0010, out_ready=1 -> out_valid one cycle after acceptance, result=12, zero=0.
REQ-032 Sub/zero test: a=b=0x1234, code 1010 -> result=0, zero=1; then a=0x7FFFFFFF, b=0xFFFFFFFF, code 0010 -> result=0x7FFFFFFE, and overflow=0 if ALU_OVERFLOW_EN is defined.
REQ-033 SLL test: b=1, shamt=31, code 0100 -> in_ready=0 for the shift duration, out_valid exactly 31 cycles after acceptance, result=0x80000000; repeat with shamt=0 -> result=1 with latency 1.
REQ-034 SLT backpressure test: a=0xFFFFFFFF, b=1, code 1011, out_ready=0 for 5 cycles -> result=1 held stable with out_valid=1 throughout; in_ready=1 after the out_ready=1 edge.
REQ-035 Illegal/overflow test: code 1111 -> result=0, illegal=1; with ALU_OVERFLOW_EN defined, a=0x7FFFFFFF, b=1, code 0010 -> result=0x80000000, overflow=1.
REQ-036 Mid-shift reset test: SRL with shamt=20, reset_n=0 pulsed 10 cycles after acceptance -> out_valid=0 immediately, in_ready=1, and no result delivered.
